// File: rtl/tmip_pkg.sv
// Shared types and constants for the template-matching grayscale front-end.
// Holds frame-size decoding and the reciprocal table used for the channel average.
package tmip_pkg;

  typedef enum logic [1:0] {
    SIZE_4  = 2'd0,
    SIZE_8  = 2'd1,
    SIZE_16 = 2'd2,
    SIZE_32 = 2'd3
  } img_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // floor(sum/CH) == (sum*RECIP) >> SHIFT for every sum up to 4*(2^12-1).
  // CH=3 uses ceil(2^15/3); the error term stays below 2^15 over that range.
  localparam int unsigned AVG_RECIP_TAB [5] = '{0, 0, 1, 10923, 1};
  localparam int unsigned AVG_SHIFT_TAB [5] = '{0, 0, 1, 15, 2};

  // Returns log2 of the frame side, clamped to the largest supported side.
  function automatic int unsigned side_from_code(input img_size_e code,
                                                 input int unsigned max_log2);
    int unsigned c;
    c = int'(code);
    if (c > max_log2 - 2) c = max_log2 - 2;
    return c + 2;
  endfunction

endpackage

// File: rtl/tmip_gray_acc.sv
// Per-pixel accumulator: running max, sum and shift-weighted sum over channels.
// Result outputs already include the beat presented this cycle.
module tmip_gray_acc
  import tmip_pkg::*;
#(
  parameter int              DW  = 8,
  parameter int              CH  = 3,
  parameter logic [3*CH-1:0] WSH = 9'b010_001_010
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic          first,
  input  logic [1:0]    ch_idx,
  input  logic [DW-1:0] pix,
  output logic [DW-1:0] res_max,
  output logic [DW-1:0] res_avg,
  output logic [DW-1:0] res_wgt
);

  localparam int          SW    = DW + 2;
  localparam int          PW    = SW + 16;
  localparam int unsigned RECIP = AVG_RECIP_TAB[CH];
  localparam int unsigned K     = AVG_SHIFT_TAB[CH];

  logic [DW-1:0] max_q, max_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [SW-1:0] wgt_q, wgt_d;
  logic [2:0]    sh;
  logic [PW-1:0] prod;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sh = '0;
    for (int i = 0; i < CH; i++) begin
      if (ch_idx == 2'(i)) sh = WSH[3*i +: 3];
    end
    if (first) begin
      max_d = pix;
      sum_d = SW'(pix);
      wgt_d = SW'(pix >> sh);
    end else begin
      max_d = (pix > max_q) ? pix : max_q;
      sum_d = sum_q + SW'(pix);
      wgt_d = wgt_q + SW'(pix >> sh);
    end
  end

  // NOTE: state uses non-blocking assignments; the accumulators are plain flops
  // (not a memory), so they take the async reset like any other control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      sum_q <= '0;
      wgt_q <= '0;
    end else if (clear) begin
      max_q <= '0;
      sum_q <= '0;
      wgt_q <= '0;
    end else if (en) begin
      max_q <= max_d;
      sum_q <= sum_d;
      wgt_q <= wgt_d;
    end
  end

  assign prod    = PW'(sum_d) * PW'(RECIP);
  assign res_max = max_d;
  assign res_avg = DW'(prod >> K);
  // Saturation compares the full-width sum before truncating.
  assign res_wgt = (wgt_d > SW'((1 << DW) - 1)) ? '1 : DW'(wgt_d);

endmodule

// File: rtl/tmip_gray_stream.sv
// Grayscale front-end: one channel component per accepted beat, one registered
// result beat (max, avg, weighted) per completed pixel, tagged with raster address.
module tmip_gray_stream
  import tmip_pkg::*;
#(
  parameter int              DW            = 8,
  parameter int              CH            = 3,
  parameter int              SIDE_LOG2_MAX = 4,
  parameter logic [3*CH-1:0] WSH           = 9'b010_001_010
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DW-1:0]              pix_in,
  input  logic [1:0]                 image_size,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [DW-1:0]              gray_max,
  output logic [DW-1:0]              gray_avg,
  output logic [DW-1:0]              gray_wgt,
  output logic [2*SIDE_LOG2_MAX-1:0] out_addr,
  output logic                       frame_done
);

  localparam int AW = 2 * SIDE_LOG2_MAX;

  state_e        state_q, state_d;
  logic [1:0]    ch_q;
  logic [AW-1:0] pix_q;
  logic [AW-1:0] last_idx_q;
  logic          beat, pix_done, frame_end;
  logic [DW-1:0] res_max, res_avg, res_wgt;

  // flush outranks in_valid: a beat arriving with flush is dropped.
  assign beat      = in_valid & ~flush;
  assign pix_done  = beat && (state_q == RUN) && (ch_q == 2'(CH - 1));
  assign frame_end = pix_done && (pix_q == last_idx_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat) state_d = RUN;
      RUN:     if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q       <= '0;
      pix_q      <= '0;
      last_idx_q <= '0;
    end else if (flush) begin
      ch_q  <= '0;
      pix_q <= '0;
    end else if (beat) begin
      // Frame size is only sampled on the first beat of a frame.
      if (state_q == IDLE)
        last_idx_q <= AW'((32'd1 << (2 * side_from_code(img_size_e'(image_size),
                                                        int'(SIDE_LOG2_MAX)))) - 32'd1);
      if (ch_q == 2'(CH - 1)) begin
        ch_q  <= '0;
        pix_q <= frame_end ? '0 : pix_q + AW'(1);
      end else begin
        ch_q <= ch_q + 2'd1;
      end
    end
  end

  tmip_gray_acc #(
    .DW  (DW),
    .CH  (CH),
    .WSH (WSH)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .en      (beat),
    .first   (ch_q == 2'd0),
    .ch_idx  (ch_q),
    .pix     (pix_in),
    .res_max (res_max),
    .res_avg (res_avg),
    .res_wgt (res_wgt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      gray_max   <= '0;
      gray_avg   <= '0;
      gray_wgt   <= '0;
      out_addr   <= '0;
    end else begin
      out_valid  <= pix_done;
      frame_done <= frame_end;
      if (pix_done) begin
        gray_max <= res_max;
        gray_avg <= res_avg;
        gray_wgt <= res_wgt;
        out_addr <= pix_q;
      end
    end
  end

endmodule

// File: tb/tb_tmip_gray_stream.sv
// Directed bench for tmip_gray_stream: three instances cover default weights,
// zero weights (saturation) and the CH=4/DW=10 clamped-size configuration.
module tb_tmip_gray_stream;

  typedef struct {
    int mx;
    int av;
    int wg;
    int addr;
    int done;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, flush;
  logic [7:0] pix_in;
  logic [1:0] image_size;

  logic       a_valid, a_done, s_valid, s_done;
  logic [7:0] a_max, a_avg, a_wgt, a_addr, s_max, s_avg, s_wgt, s_addr;

  logic       w_in_valid, w_flush, w_valid, w_done;
  logic [9:0] w_pix, w_max, w_avg, w_wgt;
  logic [1:0] w_size;
  logic [7:0] w_addr;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   m_pix = 0;
  int   m_last = 0;
  bit   m_in_frame = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tmip_gray_stream u_a (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .pix_in (pix_in),
    .image_size (image_size), .flush (flush), .out_valid (a_valid),
    .gray_max (a_max), .gray_avg (a_avg), .gray_wgt (a_wgt),
    .out_addr (a_addr), .frame_done (a_done)
  );

  tmip_gray_stream #(.WSH(9'b000_000_000)) u_s (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .pix_in (pix_in),
    .image_size (image_size), .flush (flush), .out_valid (s_valid),
    .gray_max (s_max), .gray_avg (s_avg), .gray_wgt (s_wgt),
    .out_addr (s_addr), .frame_done (s_done)
  );

  tmip_gray_stream #(.DW(10), .CH(4), .SIDE_LOG2_MAX(4), .WSH(12'b000_001_010_011)) u_w (
    .clk (clk), .rst_n (rst_n), .in_valid (w_in_valid), .pix_in (w_pix),
    .image_size (w_size), .flush (w_flush), .out_valid (w_valid),
    .gray_max (w_max), .gray_avg (w_avg), .gray_wgt (w_wgt),
    .out_addr (w_addr), .frame_done (w_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int avg3(input int a, input int b, input int c);
    return (a + b + c) / 3;
  endfunction

  function automatic int wgt3(input int a, input int b, input int c);
    int w;
    w = (a >> 2) + (b >> 1) + (c >> 2);
    return (w > 255) ? 255 : w;
  endfunction

  // Scoreboard for u_a: each result must arrive on the predicted cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && a_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(a_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("a_latency", cyc, e.cyc);
        check("a_max", 32'(a_max), e.mx);
        check("a_avg", 32'(a_avg), e.av);
        check("a_wgt", 32'(a_wgt), e.wg);
        check("a_addr", 32'(a_addr), e.addr);
        check("a_done", 32'(a_done), e.done);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input int d);
    in_valid = 1'b1;
    pix_in   = 8'(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pixel(input int c0, input int c1, input int c2,
                            input int mx, input int av, input int wg, input int max_gap);
    int   cs[3];
    int   sl;
    exp_t e;
    cs = '{c0, c1, c2};
    for (int k = 0; k < 3; k++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      if (k == 0 && !m_in_frame) begin
        m_in_frame = 1;
        sl = ((image_size > 2) ? 2 : int'(image_size)) + 2;
        m_last = (1 << (2 * sl)) - 1;
      end
      if (k == 2) begin
        e = '{mx: mx, av: av, wg: wg, addr: m_pix, done: int'(m_pix == m_last), cyc: cyc + 1};
        exp_q.push_back(e);
        if (m_pix == m_last) begin
          m_pix = 0;
          m_in_frame = 0;
        end else begin
          m_pix++;
        end
      end
      beat(cs[k]);
    end
  endtask

  initial begin
    int c0, c1, c2, c3, s, w, m;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; pix_in = '0; image_size = 2'd0;
    w_in_valid = 1'b0; w_flush = 1'b0; w_pix = '0; w_size = 2'd3;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(a_valid), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_max", 32'(a_max), 0);
    check("rst_addr", 32'(a_addr), 0);
    check("rst_w_valid", 32'(w_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous 4x4 frame of (30,200,90).
    image_size = 2'd0;
    for (int i = 0; i < 16; i++) send_pixel(30, 200, 90, 200, 106, 129, 0);

    // Back-to-back frame, flushed after channel 1 of pixel 5 (flush beat dropped).
    for (int i = 0; i < 5; i++) send_pixel(10, 20, 30, 30, 20, 19, 0);
    beat(1);
    beat(2);
    image_size = 2'd1;
    in_valid = 1'b1; flush = 1'b1; pix_in = 8'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    m_pix = 0; m_in_frame = 0;
    idle(3);
    check("flush_drain", exp_q.size(), 0);

    // 8x8 frame with random gaps; size change mid-frame must be ignored.
    for (int i = 0; i < 64; i++) begin
      c0 = (i * 37 + 5) % 256;
      c1 = (i * 91 + 13) % 256;
      c2 = (i * 53 + 200) % 256;
      send_pixel(c0, c1, c2, max3(c0, c1, c2), avg3(c0, c1, c2), wgt3(c0, c1, c2), 1);
      if (i == 0) image_size = 2'd0;
    end
    idle(4);
    check("gap_drain", exp_q.size(), 0);

    // Async reset mid-pixel, then a saturating pixel from a fresh frame.
    beat(77);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_valid), 0);
    check("arst_done", 32'(a_done), 0);
    check("arst_max", 32'(a_max), 0);
    check("arst_avg", 32'(a_avg), 0);
    check("arst_wgt", 32'(a_wgt), 0);
    check("arst_addr", 32'(a_addr), 0);
    m_pix = 0; m_in_frame = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    image_size = 2'd0;
    send_pixel(255, 255, 255, 255, 255, 253, 0);
    @(negedge clk);
    check("sat_valid", 32'(s_valid), 1);
    check("sat_max", 32'(s_max), 255);
    check("sat_avg", 32'(s_avg), 255);
    check("sat_wgt", 32'(s_wgt), 255);
    check("sat_addr", 32'(s_addr), 0);
    idle(3);
    check("sat_drain", exp_q.size(), 0);

    // CH=4, DW=10, code 3 clamps to a 16x16 frame.
    w_size = 2'd3;
    w_in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      c0 = (i * 7) % 1024;
      c1 = (i * 13 + 100) % 1024;
      c2 = (i * 29 + 300) % 1024;
      c3 = (i * 3 + 1000) % 1024;
      w_pix = 10'(c0); @(posedge clk); #1;
      w_pix = 10'(c1); @(posedge clk); #1;
      w_pix = 10'(c2); @(posedge clk); #1;
      w_pix = 10'(c3); @(posedge clk); #1;
      @(negedge clk);
      s = c0 + c1 + c2 + c3;
      w = (c0 >> 3) + (c1 >> 2) + (c2 >> 1) + c3;
      if (w > 1023) w = 1023;
      m = c0;
      if (c1 > m) m = c1;
      if (c2 > m) m = c2;
      if (c3 > m) m = c3;
      check("w_valid", 32'(w_valid), 1);
      check("w_max", 32'(w_max), m);
      check("w_avg", 32'(w_avg), s >> 2);
      check("w_wgt", 32'(w_wgt), w);
      check("w_addr", 32'(w_addr), i);
      check("w_done", 32'(w_done), (i == 255) ? 1 : 0);
    end
    w_in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w_pulse", 32'(w_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tmip_gray_stream.md
# tmip_gray_stream

Parametrised grayscale front-end for the template-matching image pipeline. It accepts a raster stream of multi-channel pixels, one channel component per accepted cycle, and computes three grayscale reductions per pixel: max, average and shift-weighted sum. Results go out in a single registered beat with the pixel address. It sits between the image input port and the grayscale SRAM writers, and replaces the fixed 3-channel, 8-bit converter with one configurable in channel count, data width and maximum frame size.

## Interface
- DW, 8, component and result width (4..12)
- CH, 3, channels per pixel (2..4)
- SIDE_LOG2_MAX, 4, largest side is 2^SIDE_LOG2_MAX; image_size codes above this are clamped
- WSH, {2,1,2}, per-channel right-shift amounts for the weighted result; 3 bits each, packed CH*3, channel 0 in the LSBs

- clk  in  1  single clock, all flops rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pix_in carries a valid component this cycle
- pix_in  in  DW  component; channel order 0..CH-1 within each pixel
- image_size  in  2  frame side code: 0→4, 1→8, 2→16, 3→32; sampled on the first accepted beat of a frame
- flush  in  1  synchronous abort: clears frame state; highest priority
- out_valid  out  1  result beat valid
- gray_max  out  DW  max over channels
- gray_avg  out  DW  floor(sum/CH)
- gray_wgt  out  DW  sum of (c_i >> WSH[i]), saturated to 2^DW-1
- out_addr  out  2*SIDE_LOG2_MAX  raster index of the pixel
- frame_done  out  1  asserted with out_valid on the last pixel of the frame

## Operation
- States: IDLE, RUN.
- IDLE → RUN on the first in_valid beat. The beat is consumed as channel 0, and side = min(code, SIDE_LOG2_MAX-2) is latched.
- RUN: each in_valid beat advances ch_cnt from 0 to CH-1.
  - Running max and running sum (width DW+2) and the weighted accumulator update on every beat.
  - When ch_cnt reaches CH-1, the pixel completes: results are registered, ch_cnt resets to 0, and pix_cnt increments.
- Gaps are legal. While in_valid is low, all counters and accumulators hold, with no timeout.
- When the pixel at pix_cnt = side² - 1 completes, frame_done is pulsed and the block returns to IDLE. The next in_valid beat starts a new frame and re-samples image_size.
- Within a frame, image_size is ignored after the first beat.
- flush clears ch_cnt, pix_cnt and accumulators, forces IDLE, and suppresses any result that would issue next cycle.
  - If flush and in_valid are high in the same cycle, flush wins and the beat is dropped.
- Average is computed as sum*RECIP >> k, with RECIP a package constant chosen per CH so that the result is exact for all sums ≤ CH*(2^DW-1). For CH = 2 or 4 it is a plain shift.
- Weighted result: the saturation compare is made on the full-width sum.

## Timing
- Reset values: out_valid=0, frame_done=0, gray_*=0, out_addr=0, state IDLE, counters 0.
- Latency: out_valid rises the cycle after the clock edge that accepts channel CH-1.
- Throughput: one pixel per CH cycles when in_valid is held high. Consecutive frames run back-to-back with no bubble.
- out_valid and frame_done are single-cycle pulses. Data outputs hold their last value when out_valid=0.
- Reset mid-frame discards the partial pixel. No output follows reset until a full new pixel has arrived.
- out_addr wraps to 0 at each new frame.

## Structure
- Package tmip_pkg holds:
  - image_size code enum
  - state enum {IDLE, RUN}
  - function side_from_code
  - the per-CH reciprocal constants table for the average
- Sub-module tmip_gray_acc holds the per-pixel accumulator: running max, sum and weighted sum, with clear and final result. The top keeps the FSM, the counters and the output registers.

## Test plan
- DW=8, CH=3, code 0, 16 pixels of (30,200,90), continuous → 16 beats with max=200, avg=106, wgt=7+100+22=129; addr 0..15; frame_done only on addr 15.
- CH=3, pixel (255,255,255), WSH={0,0,0} → wgt saturates to 255, avg=255, max=255.
- Random in_valid gaps (50% duty), code 1 → 64 results with correct values in order, and no result issued during gaps.
- flush asserted after channel 1 of pixel 5 → no beat for pixel 5. The next beat starts a new frame, image_size is re-sampled, and addr restarts at 0.
- rst_n pulsed low mid-pixel → all outputs 0 asynchronously. The following complete pixel gives addr 0.
- CH=4, DW=10, code 3 with SIDE_LOG2_MAX=4 → side clamped to 16, and frame_done at addr 255 with avg = sum>>2.
